// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Register-file write-port arbiter between the single-cycle A
//               writeback and a FIFO-buffered long-latency B source, with
//               bounded B starvation and a pending-write scoreboard.
//               Optional macro RF_WB_BYPASS_EN enables write-port forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  input  logic [4:0]      a_addr,
  input  logic [XLEN-1:0] a_data,
  output logic            a_stall,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_addr,
  input  logic [XLEN-1:0] b_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_addr,
  input  logic [4:0]      rs_a,
  input  logic [4:0]      rs_b,
  output logic            busy_a,
  output logic            busy_b,
  output logic            fwd_hit_a,
  output logic            fwd_hit_b,
  output logic [XLEN-1:0] fwd_data_a,
  output logic [XLEN-1:0] fwd_data_b,
  output logic            rf_write,
  output logic [4:0]      rf_wrAddr,
  output logic [XLEN-1:0] rf_wrData
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

  logic [4:0]      r_fifo_addr [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;
  logic [31:0]     r_busy;
  logic            r_rf_write;
  logic [4:0]      r_rf_addr;
  logic [XLEN-1:0] r_rf_data;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [4:0]      w_head_addr;
  logic [XLEN-1:0] w_head_data;
  logic [31:0]     w_set_vec;
  logic [31:0]     w_clr_vec;

  assign w_full      = (r_count == C_DEPTH);
  assign w_empty     = (r_count == '0);
  assign b_ready     = !reset && !w_full;
  assign w_push      = b_valid && b_ready;
  assign w_pop       = !a_valid && !w_empty;
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign a_stall     = (r_starve == C_STARVE_MAX);

  // Storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= b_addr;
      r_fifo_data[r_wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Counts consecutive A wins while B waits at the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (a_valid && (r_starve != C_STARVE_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_write <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
    end else if (a_valid) begin
      r_rf_write <= (a_addr != 5'd0);
      r_rf_addr  <= a_addr;
      r_rf_data  <= a_data;
    end else if (w_pop) begin
      r_rf_write <= (w_head_addr != 5'd0);
      r_rf_addr  <= w_head_addr;
      r_rf_data  <= w_head_data;
    end else begin
      r_rf_write <= 1'b0;
    end
  end

  assign rf_write  = r_rf_write;
  assign rf_wrAddr = r_rf_addr;
  assign rf_wrData = r_rf_data;

  // Set is applied after clear so a same-cycle issue keeps the bit busy.
  assign w_set_vec = (issue_valid && (issue_addr != 5'd0)) ? (32'd1 << issue_addr) : 32'd0;
  assign w_clr_vec = w_pop ? (32'd1 << w_head_addr) : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_vec) | w_set_vec) & 32'hFFFF_FFFE;
    end
  end

  assign busy_a = r_busy[rs_a];
  assign busy_b = r_busy[rs_b];

`ifdef RF_WB_BYPASS_EN
  assign fwd_hit_a  = r_rf_write && (r_rf_addr == rs_a) && (rs_a != 5'd0);
  assign fwd_hit_b  = r_rf_write && (r_rf_addr == rs_b) && (rs_b != 5'd0);
  assign fwd_data_a = r_rf_data;
  assign fwd_data_b = r_rf_data;
`else
  assign fwd_hit_a  = 1'b0;
  assign fwd_hit_b  = 1'b0;
  assign fwd_data_a = '0;
  assign fwd_data_b = '0;
`endif

endmodule
`default_nettype wire
